fa12_share_ctrl: RTL and testbench
==================================

// Module: fa12_share_ctrl
// PURPOSE
//   Time-multiplexes one 12-bit ripple-carry adder (FA12) between N_REQ requesters (partial-product summation stages).
//   Round-robin arbitration, valid/ready handshake on each request port and on the single response port.
//   Registered operands and result; one sum per grant, tagged with the requester id.
// PARAMETERS
//   N_REQ  4   number of requesters (2..8)
//   W      12  operand width; fixed to the FA12 width, so the sum is W+1 = 13 bits
//   CNT_W  16  width of the completed-operation counter
// PORTS
//   clk        in   1          rising-edge clock
//   rst_n      in   1          asynchronous, active-low reset
//   req_valid  in   N_REQ      request i holds valid operands
//   req_ready  out  N_REQ      one-hot grant; handshake on req_i when valid&ready
//   req_a      in   N_REQ*W    operand A, requester i at [i*W +: W]
//   req_b      in   N_REQ*W    operand B, same packing
//   rsp_valid  out  1          rsp_sum/rsp_id valid
//   rsp_ready  in   1          consumer accepts the response
//   rsp_sum    out  W+1        a+b, carry-out in MSB
//   rsp_id     out  clog2(N_REQ)  index of the granted requester
//   busy       out  1          state != IDLE
//   ops_done   out  CNT_W      count of completed response handshakes
// BEHAVIOUR
//   - Reset: state=IDLE, rr_ptr=0, rsp_valid=0, rsp_sum=0, rsp_id=0, ops_done=0, req_ready=0, busy=0.
//     Reset mid-operation aborts: latched operands are discarded and no response is produced.
//   - FSM states IDLE, CALC, RESP.
//     - IDLE: if any req_valid, assert req_ready for the rr winner in the same cycle (combinational).
//       Latch a, b and id; next state CALC.
//     - CALC: FA12 adds the latched operands; register sum/id; next state RESP. rsp_valid rises at the RESP entry.
//     - RESP: hold rsp_valid, rsp_sum and rsp_id stable until rsp_ready.
//       On rsp_valid&rsp_ready: ops_done+1. If any req_valid in that cycle, grant the winner (back-to-back) and go to CALC.
//       Otherwise go to IDLE.
//   - req_ready is asserted only in IDLE, or in RESP when rsp_ready=1. It is never asserted in CALC. At most one bit is set.
//   - Latency: a grant in cycle t gives rsp_valid in cycle t+2. Peak throughput is 1 sum per 2 cycles.
//   - Round-robin:
//     - Search starts at rr_ptr and wraps N_REQ-1 -> 0.
//     - After a grant to i, rr_ptr = (i+1) mod N_REQ.
//     - With no grant, rr_ptr is unchanged.
//   - Arithmetic: unsigned, rsp_sum = {carry, sum[11:0]}. 0xFFF + 0xFFF = 0x1FFE. No truncation.
//   - ops_done wraps 2^CNT_W-1 -> 0 without saturating.
//   - A requester that drops valid without a handshake is not granted. Operands are sampled only on the grant cycle.
// STRUCTURE
//   - Shared package (fa12_share_pkg): state enum {IDLE, CALC, RESP}, localparam ID_W = clog2(N_REQ), SUM_W = W+1.
//   - Sub-module rr_arbiter (N_REQ): inputs req vector, rr_ptr, enable; outputs one-hot grant and binary index.
//   - One FA12 instance, fed only from the operand registers (no combinational path from req_* to rsp_*).
// TESTING
//   1 Single request: req0 a=0x123, b=0x456 -> rsp_sum=0x0579, id=0 exactly 2 cycles after grant; ops_done=1.
//   2 Carry/overflow: a=0xFFF, b=0x001 -> 0x1000; a=0xFFF, b=0xFFF -> 0x1FFE; a=0, b=0 -> 0x0000.
//   3 Fairness: all 4 valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0,1 and one response every 2 cycles.
//   4 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_* stable, req_ready all 0.
//     Then rsp_ready=1 -> next grant issued in the same cycle.
//   5 Async reset: assert rst_n=0 during CALC with req2 pending -> all outputs take reset values immediately.
//     After release, req0 is granted first (rr_ptr=0).
//   6 Counter wrap: preload ops_done near 0xFFFF (CNT_W=16) and complete 2 ops -> 0xFFFF then 0x0000.

Source files
------------

// File: rtl/fa12_share_pkg.sv
// Shared definitions for the FA12 sharing controller: FSM encodings and
// width helpers used by the top level and the round-robin arbiter.
package fa12_share_pkg;

   localparam int FA_W = 12;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   // Requester-index width; never narrower than one bit so N_REQ=1-like
   // corner cases still produce a legal vector.
   function automatic int id_w(input int n);
      int w;
      w = $clog2(n);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/fa12_share_ctrl_fa12.sv
// Plain ripple-carry adder; the carry-out lands in the MSB of the sum.
module fa12 #(
   parameter int W = 12
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output logic [W:0]   sum_o
);

   logic [W:0] c;

   assign c[0] = 1'b0;

   for (genvar i = 0; i < W; i++) begin : g_fa
      assign sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
      assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
   end

   assign sum_o[W] = c[W];

endmodule

// File: rtl/fa12_share_ctrl_rr_arbiter.sv
// Round-robin picker: first requester at or after ptr_i (wrapping), one-hot
// grant plus binary index. Nothing is granted while en_i is low.
module rr_arbiter
   import fa12_share_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int ID_W  = id_w(N_REQ)
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [ID_W-1:0]  ptr_i,
   input  logic             en_i,
   output logic [N_REQ-1:0] gnt_o,
   output logic [ID_W-1:0]  idx_o,
   output logic             vld_o
);

   logic [ID_W:0] j_c;

   // Walk from the farthest slot back to ptr_i so the nearest hit wins.
   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      vld_o = 1'b0;
      j_c   = '0;
      if (en_i) begin
         for (int k = N_REQ - 1; k >= 0; k--) begin
            j_c = {1'b0, ptr_i} + (ID_W+1)'(k);
            if (j_c >= (ID_W+1)'(N_REQ)) begin
               j_c = j_c - (ID_W+1)'(N_REQ);
            end
            if (req_i[j_c[ID_W-1:0]]) begin
               gnt_o                   = '0;
               gnt_o[j_c[ID_W-1:0]]    = 1'b1;
               idx_o                   = j_c[ID_W-1:0];
               vld_o                   = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/fa12_share_ctrl.sv
// Shares one FA12 adder among N_REQ requesters: round-robin grant, registered
// operands, registered tagged sum, valid/ready on both sides.
module fa12_share_ctrl
   import fa12_share_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int W     = FA_W,
   parameter int CNT_W = 16,
   localparam int ID_W = id_w(N_REQ)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_REQ-1:0]   req_valid,
   output logic [N_REQ-1:0]   req_ready,
   input  logic [N_REQ*W-1:0] req_a,
   input  logic [N_REQ*W-1:0] req_b,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [W:0]         rsp_sum,
   output logic [ID_W-1:0]    rsp_id,
   output logic               busy,
   output logic [CNT_W-1:0]   ops_done
);

   logic [1:0]       state_q, state_d;
   logic [ID_W-1:0]  ptr_q,   ptr_d;
   logic [W-1:0]     a_q,     a_d;
   logic [W-1:0]     b_q,     b_d;
   logic [ID_W-1:0]  gid_q,   gid_d;
   logic [W:0]       sum_q,   sum_d;
   logic [ID_W-1:0]  id_q,    id_d;
   logic             vld_q,   vld_d;
   logic [CNT_W-1:0] ops_q,   ops_d;

   logic             arb_en;
   logic [N_REQ-1:0] gnt;
   logic [ID_W-1:0]  gnt_idx;
   logic             gnt_vld;
   logic [W-1:0]     a_sel, b_sel;
   logic [W:0]       fa_sum;

   // Gating with rst_n keeps req_ready low while reset is held.
   assign arb_en = rst_n & ((state_q == ST_IDLE) |
                            ((state_q == ST_RESP) & rsp_ready));

   rr_arbiter #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_arb (
      .req_i (req_valid),
      .ptr_i (ptr_q),
      .en_i  (arb_en),
      .gnt_o (gnt),
      .idx_o (gnt_idx),
      .vld_o (gnt_vld)
   );

   always_comb begin
      a_sel = '0;
      b_sel = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (gnt[i]) begin
            a_sel = req_a[i*W +: W];
            b_sel = req_b[i*W +: W];
         end
      end
   end

   // The adder only ever sees the operand registers.
   fa12 #(.W(W)) u_fa12 (
      .a_i   (a_q),
      .b_i   (b_q),
      .sum_o (fa_sum)
   );

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      a_d     = a_q;
      b_d     = b_q;
      gid_d   = gid_q;
      sum_d   = sum_q;
      id_d    = id_q;
      vld_d   = vld_q;
      ops_d   = ops_q;
      case (state_q)
         ST_IDLE: begin
            if (gnt_vld) state_d = ST_CALC;
         end
         ST_CALC: begin
            sum_d   = fa_sum;
            id_d    = gid_q;
            vld_d   = 1'b1;
            state_d = ST_RESP;
         end
         ST_RESP: begin
            if (rsp_ready) begin
               vld_d   = 1'b0;
               ops_d   = ops_q + CNT_W'(1);
               state_d = gnt_vld ? ST_CALC : ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (gnt_vld) begin
         a_d   = a_sel;
         b_d   = b_sel;
         gid_d = gnt_idx;
         ptr_d = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         gid_q   <= '0;
         sum_q   <= '0;
         id_q    <= '0;
         vld_q   <= 1'b0;
         ops_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         a_q     <= a_d;
         b_q     <= b_d;
         gid_q   <= gid_d;
         sum_q   <= sum_d;
         id_q    <= id_d;
         vld_q   <= vld_d;
         ops_q   <= ops_d;
      end
   end

   assign req_ready = gnt;
   assign rsp_valid = vld_q;
   assign rsp_sum   = sum_q;
   assign rsp_id    = id_q;
   assign busy      = (state_q != ST_IDLE);
   assign ops_done  = ops_q;

endmodule

// File: tb/tb_fa12_share_ctrl.sv
// Randomised and directed bench for fa12_share_ctrl, checked each cycle
// against a transaction-level model (pending sum + ready time + rr pointer).
module tb_fa12_share_ctrl;

   localparam int N = 4;
   localparam int W = 12;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [N-1:0]   req_valid;
   logic [N-1:0]   req_ready, w_req_ready;
   logic [N*W-1:0] req_a, req_b;
   logic           rsp_valid, w_rsp_valid;
   logic           rsp_ready;
   logic [W:0]     rsp_sum, w_rsp_sum;
   logic [1:0]     rsp_id, w_rsp_id;
   logic           busy, w_busy;
   logic [15:0]    ops_done;
   logic [2:0]     w_ops_done;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   fa12_share_ctrl #(.N_REQ(N), .W(W), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_sum(rsp_sum), .rsp_id(rsp_id), .busy(busy), .ops_done(ops_done)
   );

   // Narrow-counter copy sharing the same stimulus, to exercise counter wrap.
   fa12_share_ctrl #(.N_REQ(N), .W(W), .CNT_W(3)) dut_w (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(w_req_ready),
      .req_a(req_a), .req_b(req_b), .rsp_valid(w_rsp_valid), .rsp_ready(rsp_ready),
      .rsp_sum(w_rsp_sum), .rsp_id(w_rsp_id), .busy(w_busy), .ops_done(w_ops_done)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model state: at most one sum in flight, visible from cycle m_rdy on.
   int          m_cyc = 0;
   int          m_ptr = 0;
   bit          m_pend = 0;
   int          m_rdy = 0;
   int          m_sum = 0;
   int          m_id = 0;
   int unsigned m_ops = 0;

   always @(negedge clk) begin
      if (rst_n !== 1'b1) begin
         m_ptr = 0; m_pend = 0; m_ops = 0;
         check("rst_req_ready", req_ready, 0);
         check("rst_rsp_valid", rsp_valid, 0);
         check("rst_busy", busy, 0);
         check("rst_ops_done", ops_done, 0);
      end else begin
         bit exp_rv, can;
         int win;
         logic [N-1:0] exp_rr;
         m_cyc++;
         exp_rv = m_pend && (m_cyc >= m_rdy);
         can    = !m_pend || (exp_rv && rsp_ready);
         win    = -1;
         if (can) begin
            for (int k = 0; k < N; k++) begin
               if (win < 0 && req_valid[(m_ptr + k) % N]) win = (m_ptr + k) % N;
            end
         end
         exp_rr = '0;
         if (win >= 0) exp_rr[win] = 1'b1;
         check("req_ready", req_ready, exp_rr);
         check("rsp_valid", rsp_valid, exp_rv);
         check("busy", busy, m_pend);
         check("ops_done", ops_done, m_ops[15:0]);
         check("w_ops_done", w_ops_done, m_ops[2:0]);
         check("w_req_ready", w_req_ready, exp_rr);
         if (exp_rv) begin
            check("rsp_sum", rsp_sum, m_sum);
            check("rsp_id", rsp_id, m_id);
         end
         if (exp_rv && rsp_ready) begin
            m_ops++;
            m_pend = 0;
         end
         if (win >= 0) begin
            m_pend = 1;
            m_sum  = int'(req_a[win*W +: W]) + int'(req_b[win*W +: W]);
            m_id   = win;
            m_rdy  = m_cyc + 2;
            m_ptr  = (win + 1) % N;
         end
      end
   end

   task automatic one_op(input int id, input logic [11:0] a, input logic [11:0] b,
                         input logic [12:0] exp, input logic [15:0] exp_ops);
      @(posedge clk); #1;
      req_valid = '0;
      req_valid[id] = 1'b1;
      req_a[id*W +: W] = a;
      req_b[id*W +: W] = b;
      rsp_ready = 1'b1;
      @(negedge clk);
      check("op_grant", req_ready, 32'd1 << id);
      @(posedge clk); #1;
      req_valid = '0;
      check("op_calc_ready", req_ready, 0);
      check("op_calc_rv", rsp_valid, 0);
      check("op_calc_busy", busy, 1);
      @(posedge clk); #1;
      check("op_rv", rsp_valid, 1);
      check("op_sum", rsp_sum, exp);
      check("op_id", rsp_id, id);
      @(posedge clk); #1;
      check("op_ops", ops_done, exp_ops);
      check("op_idle", busy, 0);
   endtask

   int  g [12];
   bit  got;

   initial begin
      rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_sum", rsp_sum, 0);
      check("reset_id", rsp_id, 0);
      rst_n = 1'b1;

      one_op(0, 12'h123, 12'h456, 13'h0579, 16'd1);
      one_op(1, 12'hFFF, 12'h001, 13'h1000, 16'd2);
      one_op(2, 12'hFFF, 12'hFFF, 13'h1FFE, 16'd3);
      one_op(3, 12'h000, 12'h000, 13'h0000, 16'd4);

      // Fairness: all valid, consumer always ready.
      @(posedge clk); #1;
      req_valid = '1; rsp_ready = 1'b1;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         g[k] = -1;
         for (int i = 0; i < N; i++) if (req_ready[i]) g[k] = i;
      end
      @(posedge clk); #1;
      req_valid = '0;
      for (int k = 0; k < 12; k++) check("fair_order", g[k], (k % 2 == 0) ? (k / 2) % 4 : -1);
      repeat (4) @(posedge clk);
      #1;
      check("fair_ops", ops_done, 10);
      check("wrap_ops", w_ops_done, 2);

      // Backpressure: pointer sits at 2, so req2 wins with 0x222+0x100.
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
         req_a[i*W +: W] = 12'(i * 'h111);
         req_b[i*W +: W] = 12'h100;
      end
      req_valid = '1; rsp_ready = 1'b0;
      got = 0;
      for (int k = 0; k < 8 && !got; k++) begin
         @(negedge clk);
         got = rsp_valid;
      end
      check("bp_wait", got, 1);
      for (int k = 0; k < 5; k++) begin
         check("bp_rv", rsp_valid, 1);
         check("bp_sum", rsp_sum, 13'h0322);
         check("bp_id", rsp_id, 2);
         check("bp_ready", req_ready, 0);
         if (k < 4) @(negedge clk);
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      @(negedge clk);
      check("bp_regrant", req_ready, 4'b1000);
      @(posedge clk); #1;
      req_valid = '0;
      repeat (4) @(posedge clk);
      #1;
      check("bp_ops", ops_done, 12);

      // Async reset during CALC with req2 still asking.
      @(posedge clk); #1;
      req_valid = 4'b0100;
      req_a[2*W +: W] = 12'h0AB; req_b[2*W +: W] = 12'h001;
      @(negedge clk);
      check("ar_grant", req_ready, 4'b0100);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      check("ar_rv", rsp_valid, 0);
      check("ar_sum", rsp_sum, 0);
      check("ar_id", rsp_id, 0);
      check("ar_busy", busy, 0);
      check("ar_ops", ops_done, 0);
      check("ar_ready", req_ready, 0);
      @(posedge clk); #1;
      rst_n = 1'b1; req_valid = '1;
      @(negedge clk);
      check("ar_first", req_ready, 4'b0001);

      // Random traffic.
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #1;
         req_valid = N'($urandom);
         for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = 12'($urandom);
            req_b[i*W +: W] = 12'($urandom);
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
      end
      @(posedge clk); #1;
      req_valid = '0; rsp_ready = 1'b1;
      repeat (4) @(posedge clk);
      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
